// File: rtl/seven_seg_if.sv
// Bus between the application logic and the seven-segment scanner.
// Ports:
//   digits     four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp         decimal-point enable per digit, 1 = lit
//   blank      per-digit force-off, 1 = dark
//   blink      per-digit blink enable
//   load       one-cycle strobe capturing digits/dp/blank/blink
//   an         anode enables, active-low, bit i = digit i
//   seg        segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick one-cycle pulse when the scan wraps from digit 3 to digit 0
interface seven_seg_if;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  // Application side: supplies the frame and observes the pins.
  modport master (
    output digits, dp, blank, blink, load,
    input  an, seg, frame_tick
  );

  // Scanner side.
  modport slave (
    input  digits, dp, blank, blink, load,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Holds a double-buffered BCD frame, scans one digit per refresh slot with an
// anode-off guard interval at the start of each slot, and supports per-digit
// blanking, decimal points and blinking.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seven_seg_if.slave: digits/dp/blank/blink/load in, an/seg/frame_tick out
// Parameters:
//   REFRESH_DIV   cycles per digit slot (>= 4)
//   GUARD         anode-off cycles at the start of each slot (1 <= GUARD < REFRESH_DIV)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  seven_seg_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IDX_W = 2;

  // One displayable frame.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } frame_t;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD nibbles are dark.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  frame_t           pend;
  frame_t           act;
  logic [BLK_W-1:0] blink_cnt;
  logic             phase;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;
  logic             frame_tick_q;

  logic             cnt_last_c;
  logic             boundary_c;
  logic             guard_c;
  logic             dark_c;
  logic [3:0]       nib_c;
  logic [3:0]       an_c;
  logic [7:0]       seg_c;
  frame_t           in_c;

  // Next-output decode from the current scan position and active buffer.
  always_comb begin
    cnt_last_c = 1'b0;
    boundary_c = 1'b0;
    guard_c    = 1'b0;
    dark_c     = 1'b0;
    nib_c      = 4'h0;
    an_c       = 4'hF;
    seg_c      = 8'hFF;
    in_c       = '{digits: bus.digits, dp: bus.dp, blank: bus.blank, blink: bus.blink};

    cnt_last_c = (cnt == CNT_W'(REFRESH_DIV - 1));
    boundary_c = cnt_last_c && (idx == 2'd3);
    guard_c    = (cnt < CNT_W'(GUARD));

    case (idx)
      2'd0:    nib_c = act.digits[3:0];
      2'd1:    nib_c = act.digits[7:4];
      2'd2:    nib_c = act.digits[11:8];
      default: nib_c = act.digits[15:12];
    endcase

    dark_c = act.blank[idx] | (act.blink[idx] & phase);

    // Guard cycles keep every anode off so no ghosting leaks between digits.
    if (!guard_c) begin
      an_c = ~(4'b0001 << idx);
      if (!dark_c) begin
        seg_c = {~act.dp[idx], decode(nib_c)};
      end
    end
  end

  // Scan counters, frame buffers, blink timing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      pend         <= '0;
      act          <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt <= cnt_last_c ? '0 : cnt + CNT_W'(1);
      if (cnt_last_c) begin
        idx <= idx + IDX_W'(1);
      end

      if (bus.load) begin
        pend <= in_c;
      end

      // A load on the boundary cycle bypasses pend so that frame is not lost.
      if (boundary_c) begin
        act <= bus.load ? in_c : pend;
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end

      an_q         <= an_c;
      seg_q        <= seg_c;
      frame_tick_q <= boundary_c;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=8, GUARD=1,
// BLINK_FRAMES=2. A time-indexed reference model derives scan position, blink
// phase and displayed frame from the elapsed cycle count since reset.
module tb_seven_seg_scanner;

  localparam int R  = 8;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FR = 4 * R;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [3:0]  bk;
  } fr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_if bus();

  seven_seg_scanner #(
    .REFRESH_DIV (R),
    .GUARD       (G),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int         t;
  fr_t        m_pend;
  fr_t        m_act;
  logic [6:0] seg_tab [16];
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_ft;
  logic [7:0] last_seg [4];

  // Advance one clock: compute expected registered outputs for model time t,
  // apply load/boundary rules, then step past the edge.
  task automatic tick();
    int c, i, fc;
    bit ph, dark, bnd;
    fr_t inb;
    logic [3:0] nib;
    c    = t % R;
    i    = (t / R) % 4;
    fc   = t / FR;
    ph   = ((fc / BF) % 2) == 1;
    bnd  = (t % FR) == FR - 1;
    inb  = {bus.digits, bus.dp, bus.blank, bus.blink};
    nib  = m_act.d[i*4 +: 4];
    dark = m_act.bl[i] | (m_act.bk[i] & ph);
    exp_an  = (c < G) ? 4'hF : 4'(~(4'b0001 << i));
    exp_seg = ((c < G) || dark) ? 8'hFF : {~m_act.dp[i], seg_tab[nib]};
    exp_ft  = bnd;
    if (bnd) m_act = bus.load ? inb : m_pend;
    if (bus.load) m_pend = inb;
    t++;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++)
      if (bus.an == 4'(~(4'b0001 << k))) last_seg[k] = bus.seg;
  endtask

  task automatic clear_last();
    for (int k = 0; k < 4; k++) last_seg[k] = 8'h00;
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] bl, input logic [3:0] bk, input logic ld);
    bus.digits = d;
    bus.dp     = dp;
    bus.blank  = bl;
    bus.blink  = bk;
    bus.load   = ld;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    t      = 0;
    m_pend = '0;
    m_act  = '0;
    clear_last();
  endtask

  task automatic test_reset();
    set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.an !== 4'hF) begin bad++; $display("FAIL reset_an got=%h exp=f", bus.an); end
    total++;
    if (bus.seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", bus.seg); end
    total++;
    if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_ft got=%b exp=0", bus.frame_tick); end
    release_reset();
    // Free-running scan of the cleared frame over two full frames.
    for (int n = 0; n < 2 * FR + 4; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL scan t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  endtask

  task automatic test_load();
    int w;
    w = int'($urandom_range(0, FR - 1));
    for (int n = 0; n < w; n++) tick();
    set_inputs(16'h1234, 4'b0100, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 3 * FR; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL load t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (exp_ft) break;
    end
    clear_last();
    for (int n = 0; n < FR; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL load_frame t=%0d got an=%h seg=%h exp an=%h seg=%h",
                 t - 1, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
    total++;
    if (last_seg[0] !== 8'h99) begin bad++; $display("FAIL load_d0 got=%h exp=99", last_seg[0]); end
    total++;
    if (last_seg[1] !== 8'hB0) begin bad++; $display("FAIL load_d1 got=%h exp=b0", last_seg[1]); end
    total++;
    if (last_seg[2] !== 8'h24) begin bad++; $display("FAIL load_d2 got=%h exp=24", last_seg[2]); end
    total++;
    if (last_seg[3] !== 8'hF9) begin bad++; $display("FAIL load_d3 got=%h exp=f9", last_seg[3]); end
  endtask

  task automatic test_boundary_load();
    while ((t % FR) != FR - 1) tick();
    set_inputs(16'h0009, 4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    total++;
    if (bus.frame_tick !== 1'b1) begin bad++; $display("FAIL bnd_tick got=%b exp=1", bus.frame_tick); end
    clear_last();
    while ((t % FR) != 16) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL bnd t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
    total++;
    if (last_seg[0] !== 8'h90) begin bad++; $display("FAIL bnd_d0 got=%h exp=90", last_seg[0]); end
    // Mid-frame reload waits for the following boundary.
    set_inputs(16'h0005, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 2 * FR; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL mid t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (exp_ft) break;
    end
    clear_last();
    for (int n = 0; n < FR; n++) tick();
    total++;
    if (last_seg[0] !== 8'h92) begin bad++; $display("FAIL mid_d0 got=%h exp=92", last_seg[0]); end
  endtask

  task automatic test_blank();
    set_inputs(16'hA000, 4'h0, 4'b1000, 4'h0, 1'b1);
    for (int n = 0; n < 2 * FR; n++) begin
      tick();
      if (exp_ft) break;
    end
    clear_last();
    for (int n = 0; n < FR; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL blank t=%0d got an=%h seg=%h exp an=%h seg=%h",
                 t - 1, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
    total++;
    if (last_seg[3] !== 8'hFF) begin bad++; $display("FAIL blank_d3 got=%h exp=ff", last_seg[3]); end
    set_inputs(16'hA000, 4'b1000, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 2 * FR; n++) begin
      tick();
      if (exp_ft) break;
    end
    clear_last();
    for (int n = 0; n < FR; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL dp_only t=%0d got an=%h seg=%h exp an=%h seg=%h",
                 t - 1, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
    total++;
    if (last_seg[3] !== 8'h7F) begin bad++; $display("FAIL dp_only_d3 got=%h exp=7f", last_seg[3]); end
  endtask

  task automatic test_blink();
    int dark_frames;
    logic [15:0] d;
    d = {4'(($urandom % 10)), 4'(($urandom % 10)), 4'(($urandom % 10)), 4'(($urandom % 10))};
    set_inputs(d, 4'h0, 4'h0, 4'b0001, 1'b1);
    for (int n = 0; n < 2 * FR; n++) begin
      tick();
      if (exp_ft) break;
    end
    dark_frames = 0;
    for (int f = 0; f < 4; f++) begin
      clear_last();
      for (int n = 0; n < FR; n++) begin
        tick();
        total++;
        if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
          bad++;
          $display("FAIL blink t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                   t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
        end
      end
      if (last_seg[0] == 8'hFF) dark_frames++;
      total++;
      if (last_seg[1] === 8'hFF) begin bad++; $display("FAIL blink_d1 frame=%0d got=ff exp=lit", f); end
    end
    total++;
    if (dark_frames != 2) begin bad++; $display("FAIL blink_duty got=%0d exp=2", dark_frames); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_inputs(16'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0));
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL rand t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  endtask

  task automatic test_async_reset();
    set_inputs(16'h0008, 4'b0001, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 2 * FR; n++) begin
      tick();
      if (exp_ft) break;
    end
    set_inputs(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
    while ((t % FR) != 4) tick();
    total++;
    if ({bus.an, bus.seg} !== {exp_an, exp_seg}) begin
      bad++;
      $display("FAIL pre_rst got an=%h seg=%h exp an=%h seg=%h", bus.an, bus.seg, exp_an, exp_seg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.an !== 4'hF) begin bad++; $display("FAIL async_an got=%h exp=f", bus.an); end
    total++;
    if (bus.seg !== 8'hFF) begin bad++; $display("FAIL async_seg got=%h exp=ff", bus.seg); end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.an, bus.seg} !== 12'hFFF) begin
      bad++;
      $display("FAIL held_rst got an=%h seg=%h exp an=f seg=ff", bus.an, bus.seg);
    end
    release_reset();
    for (int n = 0; n < FR + 2; n++) begin
      tick();
      total++;
      if ({bus.an, bus.seg, bus.frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL post_rst t=%0d got an=%h seg=%h ft=%b exp an=%h seg=%h ft=%b",
                 t - 1, bus.an, bus.seg, bus.frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
    // Buffers cleared: digit 0 shows nibble 0 without the old decimal point.
    total++;
    if (last_seg[0] !== 8'hC0) begin bad++; $display("FAIL post_rst_d0 got=%h exp=c0", last_seg[0]); end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'h7F;
    t = 0;
    m_pend = '0;
    m_act  = '0;
    test_reset();
    test_load();
    test_boundary_load();
    test_blank();
    test_blink();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
